// File: rtl/iccm_prog_loader.sv
// Boot-programming framer: UART byte stream -> sequential 32-bit ICCM writes.
// Optional trailer checksum check is enabled by defining PROG_CHECKSUM_EN.
module iccm_prog_loader #(
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prog_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        we_o,
  output logic [11:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        prog_rst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef PROG_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [10:0]   word_cnt_q, word_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          prog_rst_n_q, prog_rst_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic [15:0] len_w;
  logic        last_word_w;
  logic        in_frame_w;
  logic        busy_next_w;

  assign len_w       = {rx_byte_i, count_q[7:0]};
  assign last_word_w = ({5'd0, word_cnt_q} + 16'd1) == count_q;

`ifdef PROG_CHECKSUM_EN
  assign in_frame_w  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHK);
  assign busy_next_w = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA)   || (state_d == S_CHK);
`else
  assign in_frame_w  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA);
  assign busy_next_w = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
`ifdef PROG_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_dv_i && (rx_byte_i == SYNC_BYTE)) begin
          state_d    = S_LEN_LO;
          byte_cnt_d = 2'd0;
          word_cnt_d = 11'd0;
          addr_d     = 12'd0;
`ifdef PROG_CHECKSUM_EN
          xor_d      = 8'd0;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_dv_i) begin
          count_d = {8'h00, rx_byte_i};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_dv_i) begin
          count_d = len_w;
          if ((len_w == 16'd0) || (len_w > 16'(MAX_WORDS))) begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_dv_i) begin
`ifdef PROG_CHECKSUM_EN
          xor_d = xor_q ^ rx_byte_i;
`endif
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word: write it and start a fresh one.
            we_d       = 1'b1;
            wdata_d    = {rx_byte_i, shift_q};
            addr_d     = {1'b0, word_cnt_q};
            word_cnt_d = word_cnt_q + 11'd1;
            byte_cnt_d = 2'd0;
            if (last_word_w) begin
`ifdef PROG_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            shift_d    = {rx_byte_i, shift_q[23:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
`ifdef PROG_CHECKSUM_EN
      S_CHK: begin
        if (rx_dv_i) begin
          if (rx_byte_i == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = 2'd3;
          end
        end
      end
`endif
      default: ;
    endcase

    // Inter-byte watchdog; a received byte always resets it.
    if (in_frame_w) begin
      if (rx_dv_i) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = S_ERR;
        err_code_d = 2'd2;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // Leaving programming mode overrides everything, including a byte this cycle.
    if (!prog_i) begin
      state_d    = S_IDLE;
      byte_cnt_d = 2'd0;
      shift_d    = 24'd0;
      tmo_d      = '0;
      we_d       = 1'b0;
      err_code_d = 2'd0;
    end

    busy_d       = busy_next_w;
    err_d        = (state_d == S_ERR);
    done_d       = (state_d == S_DONE) && (state_q != S_DONE);
    prog_rst_n_d = !(prog_i && (state_d != S_DONE));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      count_q      <= 16'd0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      word_cnt_q   <= 11'd0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= 12'd0;
      wdata_q      <= 32'd0;
      prog_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
`ifdef PROG_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_cnt_q   <= word_cnt_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      prog_rst_n_q <= prog_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
`ifdef PROG_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_rst_no = prog_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
